station_sequencer: RTL and testbench
====================================

// Module: station_sequencer
// PURPOSE
//  Top-level sequencer for one disinfection/access station. On a start request from
//  the access gate it waits for a hand, runs the sanitizer pump for a timed dose,
//  opens the door for a fixed window, then cools down.
//  It counts doses and requests a tank refill. It replaces free-running pump
//  enabling with a single-owner FSM that drives pump and door.
// PARAMETERS
//  TICK_DIV        50000  clk cycles per timer tick (1 ms at 50 MHz)
//  DEB_CYC         1000   clk cycles sensor must be stable before hand state changes
//  HAND_TIMEOUT_MS 5000   ticks allowed in WAIT_HAND before abort
//  DOSE_MS         500    ticks pump stays on for one dose
//  GRANT_MS        3000   ticks door_open stays asserted
//  COOLDOWN_MS     1000   ticks of lockout after grant
//  MAX_DOSES       200    dose count that raises refill_req (1..255)
// PORTS
//  clk          in   1  system clock
//  rst          in   1  synchronous reset, active high
//  start        in   1  one-cycle request from access gate (user cleared)
//  sensor_n     in   1  hand sensor, async, active low (0 = hand present)
//  refill_ack   in   1  tank refilled; clears dose counter
//  bomba_n      out  1  pump drive, active low (0 = pump on)
//  door_open    out  1  door release
//  busy         out  1  high in every state except IDLE
//  done         out  1  one-cycle pulse when COOLDOWN completes
//  alarm_to     out  1  one-cycle pulse on hand timeout
//  refill_req   out  1  level: dose_count reached MAX_DOSES
//  dose_count   out  8  completed doses since reset/refill
// BEHAVIOUR
//  Reset: state=IDLE; bomba_n=1; door_open=busy=done=alarm_to=refill_req=0.
//  Reset also clears dose_count=0, sync flops=1, hand_present=0 and all counters.
//  Reset mid-dose drops the pump on the next edge.
//  Input path: sensor_n goes through a 2-flop synchronizer, then a debouncer.
//  hand_present changes only after the synced level differs from it for
//  DEB_CYC consecutive cycles; any bounce restarts the count.
//  Timer: prescaler and tick counter are reloaded on every state entry.
//  A state with duration N lasts exactly N*TICK_DIV cycles.
//  All outputs are registered and are Moore functions of the state,
//  valid in the first cycle of the state.
//  States / transitions:
//   IDLE:      start & !refill_req -> WAIT_HAND; start while refill_req is ignored.
//   WAIT_HAND: hand_present -> DISPENSE.
//              HAND_TIMEOUT_MS expires -> IDLE, alarm_to pulse.
//   DISPENSE:  bomba_n=0. !hand_present -> WAIT_HAND: pump off, fresh timeout, no count.
//              DOSE_MS expires -> GRANT, dose_count+1, saturating at 255.
//   GRANT:     door_open=1; GRANT_MS expires -> COOLDOWN.
//   COOLDOWN:  all off; COOLDOWN_MS expires -> IDLE, done pulse.
//  Hand lost and timer expiry in the same cycle: expiry wins, so the dose counts.
//  Gating: start is ignored outside IDLE. bomba_n=0 only in DISPENSE;
//  door_open=1 only in GRANT; never both.
//  refill_req is set the cycle after dose_count becomes >= MAX_DOSES.
//  refill_ack is honoured only while refill_req=1; it clears dose_count and
//  refill_req next cycle.
//  refill_ack with start in IDLE: the ack is taken and start is dropped.
// TESTING (TICK_DIV=4 DEB_CYC=2 HAND_TIMEOUT_MS=10 DOSE_MS=5 GRANT_MS=6 COOLDOWN_MS=3 MAX_DOSES=2)
//  1 Normal: start, sensor_n=0 held -> bomba_n=0 for 20 cyc, door_open=1 24 cyc,
//    done pulse 12 cyc later, dose_count=1.
//  2 Timeout: start, no hand -> alarm_to pulse after 40 cyc, IDLE, bomba_n never 0.
//  3 Bounce/abort: 1-cycle sensor glitches keep WAIT_HAND. Hand removed mid-dose
//    -> bomba_n=1 within 4 cyc, dose_count unchanged.
//  4 Refill: two full cycles -> refill_req=1, next start ignored.
//    refill_ack -> dose_count=0, refill_req=0, start accepted.
//  5 Reset mid-DISPENSE -> bomba_n=1 next edge, all outputs at reset values.
//  6 start pulses during GRANT/COOLDOWN -> ignored, exactly one done pulse.

Source files
------------

// File: rtl/station_sequencer.sv
// Sequencer for one disinfection/access station: wait for a hand, dose the
// sanitizer pump, release the door, then lock out for a cooldown period.
module station_sequencer #(
  parameter int unsigned TICK_DIV        = 50000,
  parameter int unsigned DEB_CYC         = 1000,
  parameter int unsigned HAND_TIMEOUT_MS = 5000,
  parameter int unsigned DOSE_MS         = 500,
  parameter int unsigned GRANT_MS        = 3000,
  parameter int unsigned COOLDOWN_MS     = 1000,
  parameter int unsigned MAX_DOSES       = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       sensor_n,
  input  logic       refill_ack,
  output logic       bomba_n,
  output logic       door_open,
  output logic       busy,
  output logic       done,
  output logic       alarm_to,
  output logic       refill_req,
  output logic [7:0] dose_count
);

  // state     | meaning
  // IDLE      | waiting for start from the access gate
  // WAIT_HAND | armed, waiting for a debounced hand (timeout aborts)
  // DISPENSE  | pump on for one dose
  // GRANT     | door released
  // COOLDOWN  | lockout, everything off
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_HAND = 3'd1,
    DISPENSE  = 3'd2,
    GRANT     = 3'd3,
    COOLDOWN  = 3'd4
  } state_t;

  localparam int unsigned MAX_A  = (HAND_TIMEOUT_MS > DOSE_MS) ? HAND_TIMEOUT_MS : DOSE_MS;
  localparam int unsigned MAX_B  = (GRANT_MS > COOLDOWN_MS) ? GRANT_MS : COOLDOWN_MS;
  localparam int unsigned MAX_MS = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int PRE_W  = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int TICK_W = (MAX_MS > 2) ? $clog2(MAX_MS) : 1;
  localparam int DEB_W  = (DEB_CYC > 2) ? $clog2(DEB_CYC) : 1;

  localparam logic [PRE_W-1:0]  PRE_RELOAD = PRE_W'(TICK_DIV - 1);
  localparam logic [DEB_W-1:0]  DEB_RELOAD = DEB_W'(DEB_CYC - 1);
  localparam logic [TICK_W-1:0] T_WAIT     = TICK_W'(HAND_TIMEOUT_MS - 1);
  localparam logic [TICK_W-1:0] T_DOSE     = TICK_W'(DOSE_MS - 1);
  localparam logic [TICK_W-1:0] T_GRANT    = TICK_W'(GRANT_MS - 1);
  localparam logic [TICK_W-1:0] T_COOL     = TICK_W'(COOLDOWN_MS - 1);
  localparam logic [7:0]        DOSE_LIMIT = 8'(MAX_DOSES);

  state_t             state_q, state_d;
  logic               sync1_q, sync2_q;
  logic               hand_q, hand_d;
  logic [DEB_W-1:0]   deb_q, deb_d;
  logic [PRE_W-1:0]   pre_q;
  logic [TICK_W-1:0]  tick_q, tick_reload;
  logic               expire;
  logic [7:0]         dose_q;
  logic               refill_req_q, ack_take;
  logic               bomba_n_q, door_open_q, busy_q, done_q, alarm_to_q;

  // Debouncer: hand state flips only after DEB_CYC consecutive differing cycles.
  always_comb begin
    hand_d = hand_q;
    deb_d  = DEB_RELOAD;
    if (~sync2_q != hand_q) begin
      if (deb_q == '0) begin
        hand_d = ~sync2_q;
      end else begin
        deb_d = deb_q - 1'b1;
      end
    end
  end

  assign expire   = (pre_q == '0) && (tick_q == '0);
  assign ack_take = refill_ack && refill_req_q;

  // Next state uses hand_d so a debounced hand change acts on the same edge.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (start && !refill_req_q) state_d = WAIT_HAND;
      WAIT_HAND: if (hand_d)                 state_d = DISPENSE;
                 else if (expire)            state_d = IDLE;
      DISPENSE:  if (expire)                 state_d = GRANT;
                 else if (!hand_d)           state_d = WAIT_HAND;
      GRANT:     if (expire)                 state_d = COOLDOWN;
      COOLDOWN:  if (expire)                 state_d = IDLE;
      default:                               state_d = IDLE;
    endcase
  end

  always_comb begin
    tick_reload = '0;
    unique case (state_d)
      WAIT_HAND: tick_reload = T_WAIT;
      DISPENSE:  tick_reload = T_DOSE;
      GRANT:     tick_reload = T_GRANT;
      COOLDOWN:  tick_reload = T_COOL;
      default:   tick_reload = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      hand_q       <= 1'b0;
      deb_q        <= '0;
      pre_q        <= '0;
      tick_q       <= '0;
      dose_q       <= '0;
      refill_req_q <= 1'b0;
      bomba_n_q    <= 1'b1;
      door_open_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      alarm_to_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync1_q <= sensor_n;
      sync2_q <= sync1_q;
      hand_q  <= hand_d;
      deb_q   <= deb_d;

      if (state_d != state_q) begin
        pre_q  <= PRE_RELOAD;
        tick_q <= tick_reload;
      end else if (pre_q == '0) begin
        pre_q <= PRE_RELOAD;
        if (tick_q != '0) tick_q <= tick_q - 1'b1;
      end else begin
        pre_q <= pre_q - 1'b1;
      end

      if (ack_take) begin
        dose_q <= '0;
      end else if (state_q == DISPENSE && expire && dose_q != 8'hFF) begin
        dose_q <= dose_q + 8'd1;
      end
      refill_req_q <= ack_take ? 1'b0 : (dose_q >= DOSE_LIMIT);

      bomba_n_q   <= (state_d != DISPENSE);
      door_open_q <= (state_d == GRANT);
      busy_q      <= (state_d != IDLE);
      done_q      <= (state_q == COOLDOWN) && (state_d == IDLE);
      alarm_to_q  <= (state_q == WAIT_HAND) && (state_d == IDLE);
    end
  end

  assign bomba_n    = bomba_n_q;
  assign door_open  = door_open_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign alarm_to   = alarm_to_q;
  assign refill_req = refill_req_q;
  assign dose_count = dose_q;

endmodule

// File: tb/tb_station_sequencer.sv
// Directed bench for station_sequencer with short timing parameters.
module tb_station_sequencer;

  logic       clk = 1'b0;
  logic       rst, start, sensor_n, refill_ack;
  logic       bomba_n, door_open, busy, done, alarm_to, refill_req;
  logic [7:0] dose_count;

  int checks = 0;
  int errors = 0;
  int n, m, pump, both, dn;

  localparam int SEL_BOMBA = 0;
  localparam int SEL_DOOR  = 1;
  localparam int SEL_DONE  = 2;
  localparam int SEL_ALARM = 3;

  station_sequencer #(
    .TICK_DIV(4), .DEB_CYC(2), .HAND_TIMEOUT_MS(10), .DOSE_MS(5),
    .GRANT_MS(6), .COOLDOWN_MS(3), .MAX_DOSES(2)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .sensor_n(sensor_n),
    .refill_ack(refill_ack), .bomba_n(bomba_n), .door_open(door_open),
    .busy(busy), .done(done), .alarm_to(alarm_to),
    .refill_req(refill_req), .dose_count(dose_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic out_sel(input int which);
    case (which)
      SEL_BOMBA: return bomba_n;
      SEL_DOOR:  return door_open;
      SEL_DONE:  return done;
      SEL_ALARM: return alarm_to;
      default:   return busy;
    endcase
  endfunction

  task automatic wait_out(input int which, input logic val, input int limit, output int cnt);
    cnt = 0;
    while (out_sel(which) !== val && cnt < limit) begin
      step();
      cnt++;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_bomba_n"},    bomba_n,    1);
    check({tag, "_door_open"},  door_open,  0);
    check({tag, "_busy"},       busy,       0);
    check({tag, "_done"},       done,       0);
    check({tag, "_alarm_to"},   alarm_to,   0);
    check({tag, "_refill_req"}, refill_req, 0);
    check({tag, "_dose_count"}, dose_count, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; sensor_n = 1'b1; refill_ack = 1'b0;
    repeat (3) step();
    check_reset_outputs("reset");
    rst = 1'b0;
    step();

    // Normal dose with the hand held from the start
    start = 1'b1; sensor_n = 1'b0;
    step();
    start = 1'b0;
    check("busy_after_start", busy, 1);
    wait_out(SEL_BOMBA, 1'b0, 20, m);
    check("hand_latency", 1 + m, 4);
    n = 0; both = 0;
    while (bomba_n === 1'b0 && n < 40) begin
      if (door_open === 1'b1) both++;
      step();
      n++;
    end
    check("dose_len", n, 20);
    check("pump_door_overlap", both, 0);
    check("door_in_grant", door_open, 1);
    n = 0;
    while (door_open === 1'b1 && n < 40) begin
      step();
      n++;
    end
    check("grant_len", n, 24);
    wait_out(SEL_DONE, 1'b1, 30, n);
    check("cooldown_len", n, 12);
    check("dose_after_normal", dose_count, 1);
    step();
    check("done_one_cycle", done, 0);
    check("idle_after_done", busy, 0);
    sensor_n = 1'b1;
    repeat (6) step();

    // Hand timeout
    start = 1'b1;
    step();
    start = 1'b0;
    n = 1; pump = 0;
    while (alarm_to !== 1'b1 && n < 60) begin
      if (bomba_n === 1'b0) pump = 1;
      step();
      n++;
    end
    check("timeout_len", n, 41);
    check("timeout_no_pump", pump, 0);
    step();
    check("alarm_one_cycle", alarm_to, 0);
    check("idle_after_timeout", busy, 0);

    // Sensor glitches, then hand removed mid-dose
    start = 1'b1;
    step();
    start = 1'b0;
    for (int g = 0; g < 3; g++) begin
      sensor_n = 1'b0;
      step();
      sensor_n = 1'b1;
      repeat (3) step();
    end
    repeat (4) step();
    check("glitch_no_pump", bomba_n, 1);
    check("glitch_still_waiting", busy, 1);
    sensor_n = 1'b0;
    wait_out(SEL_BOMBA, 1'b0, 8, n);
    check("hand_latency2", n, 4);
    repeat (8) step();
    sensor_n = 1'b1;
    wait_out(SEL_BOMBA, 1'b1, 10, n);
    check("abort_latency", n, 4);
    check("abort_no_count", dose_count, 1);
    check("abort_busy", busy, 1);
    wait_out(SEL_ALARM, 1'b1, 60, n);
    check("fresh_timeout", n, 40);
    step();

    // Second full dose reaches the refill threshold
    start = 1'b1; sensor_n = 1'b0;
    step();
    start = 1'b0;
    wait_out(SEL_DONE, 1'b1, 120, n);
    check("second_cycle_done", n < 120, 1);
    sensor_n = 1'b1;
    repeat (6) step();
    check("dose_at_limit", dose_count, 2);
    check("refill_req_set", refill_req, 1);
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    check("start_ignored_refill", busy, 0);
    refill_ack = 1'b1; start = 1'b1;
    step();
    refill_ack = 1'b0; start = 1'b0;
    check("ack_clears_dose", dose_count, 0);
    check("ack_clears_req", refill_req, 0);
    check("ack_drops_start", busy, 0);
    step();
    check("req_stays_clear", refill_req, 0);

    // Accepted start after refill; start pulses during GRANT/COOLDOWN
    start = 1'b1; sensor_n = 1'b0;
    step();
    start = 1'b0;
    check("start_after_ack", busy, 1);
    wait_out(SEL_DOOR, 1'b1, 40, n);
    check("grant_entry", n, 23);
    dn = 0;
    for (int k = 0; k < 46; k++) begin
      if (done === 1'b1) dn++;
      start = (k % 7 == 0) && (k <= 35);
      step();
    end
    start = 1'b0;
    check("single_done", dn, 1);
    check("idle_after_pulses", busy, 0);
    check("dose_after_refill", dose_count, 1);
    sensor_n = 1'b1; refill_ack = 1'b1;
    step();
    refill_ack = 1'b0;
    check("ack_ignored_no_req", dose_count, 1);
    repeat (5) step();

    // Reset in the middle of a dose
    start = 1'b1; sensor_n = 1'b0;
    step();
    start = 1'b0;
    wait_out(SEL_BOMBA, 1'b0, 10, n);
    repeat (3) step();
    check("pump_before_reset", bomba_n, 0);
    rst = 1'b1; sensor_n = 1'b1;
    step();
    check_reset_outputs("midreset");
    rst = 1'b0;
    repeat (2) step();
    check("idle_after_midreset", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
